// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//
// Byte-transfer engine that sits behind spi_mode_config. It frames a transfer
// with chip select, drives MOSI MSB-first on shift_edge pulses, samples MISO on
// capture_edge pulses, and reports busy/done to the controlling logic.
// sclk_en gates the upstream SCLK source so edges only arrive in the data phase.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         transfer request, honoured only while idle
//   tx_data_i       word to transmit, latched when start is accepted
//   cpha_i          clock phase, latched when start is accepted
//   capture_edge_i  one-clk pulse: sample MISO
//   shift_edge_i    one-clk pulse: update MOSI
//   miso_i          serial data in (already synchronised)
//   mosi_o          serial data out
//   cs_n_o          chip select, active low
//   sclk_en_o       enables upstream SCLK generation
//   busy_o          high from accepted start until done
//   done_o          one-clk pulse when the transfer completes
//   rx_data_o       last received word, stable until the next done
//
// States
//   S_IDLE   | waiting for start, CS high
//   S_SETUP  | CS low, counting setup clocks before SCLK is enabled
//   S_XFER   | SCLK enabled, shifting/capturing bits
//   S_HOLD   | SCLK disabled, counting hold clocks before CS release
//   S_FINISH | CS high, done pulse, rx_data updated (one clk)
// -----------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  cpha_i,
    input  logic                  capture_edge_i,
    input  logic                  shift_edge_i,
    input  logic                  miso_i,
    output logic                  mosi_o,
    output logic                  cs_n_o,
    output logic                  sclk_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rx_data_o
);

    localparam int CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam int IDX_W    = $clog2(DATA_WIDTH);
    localparam int WAIT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
    localparam logic [WAIT_W-1:0] SETUP_LOAD = WAIT_W'(SETUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] HOLD_LOAD  = WAIT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t                state_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_sreg_q;
    logic [DATA_WIDTH-1:0] rx_sreg_q, rx_sreg_d;
    logic                  cpha_q;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q;
    logic                  sclk_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [IDX_W-1:0]      tx_idx;

    // Data-phase datapath. A capture and a shift in the same clk resolve as
    // capture first: the shift indexes with the already-incremented count.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_sreg_d = rx_sreg_q;
        mosi_d    = mosi_q;
        tx_idx    = '0;
        if (state_q == S_XFER) begin
            if (capture_edge_i) begin
                rx_sreg_d = {rx_sreg_q[DATA_WIDTH-2:0], miso_i};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            tx_idx = IDX_LAST - bit_cnt_d[IDX_W-1:0];
            if (shift_edge_i) begin
                if (bit_cnt_d == '0) begin
                    // MSB is already on the line from start; CPHA=1 simply
                    // re-drives it on its leading shift edge.
                    if (cpha_q) begin
                        mosi_d = tx_sreg_q[DATA_WIDTH-1];
                    end
                end else if (bit_cnt_d != CNT_FULL) begin
                    mosi_d = tx_sreg_q[tx_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bit_cnt_q <= '0;
            tx_sreg_q <= '0;
            rx_sreg_q <= '0;
            cpha_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_SETUP;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        tx_sreg_q <= tx_data_i;
                        cpha_q    <= cpha_i;
                        mosi_q    <= tx_data_i[DATA_WIDTH-1];
                        bit_cnt_q <= '0;
                        wait_q    <= SETUP_LOAD;
                    end
                end
                S_SETUP: begin
                    if (wait_q == '0) begin
                        state_q   <= S_XFER;
                        sclk_en_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_XFER: begin
                    bit_cnt_q <= bit_cnt_d;
                    rx_sreg_q <= rx_sreg_d;
                    mosi_q    <= mosi_d;
                    if (bit_cnt_d == CNT_FULL) begin
                        state_q   <= S_HOLD;
                        sclk_en_q <= 1'b0;
                        wait_q    <= HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    if (wait_q == '0) begin
                        state_q   <= S_FINISH;
                        cs_n_q    <= 1'b1;
                        rx_data_q <= rx_sreg_q;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        mosi_q    <= 1'b0;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;
    assign sclk_en_o = sclk_en_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;

    localparam int DW      = 8;
    localparam int SETUP_C = 2;
    localparam int HOLD_C  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          cpha = 1'b0;
    logic          cap = 1'b0;
    logic          shf = 1'b0;
    logic          miso = 1'b0;
    logic          mosi, cs_n, sclk_en, busy, done;
    logic [DW-1:0] rx_data;

    always #5 clk = ~clk;

    spi_shift_engine #(
        .DATA_WIDTH  (DW),
        .SETUP_CYCLES(SETUP_C),
        .HOLD_CYCLES (HOLD_C)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .tx_data_i     (tx_data),
        .cpha_i        (cpha),
        .capture_edge_i(cap),
        .shift_edge_i  (shf),
        .miso_i        (miso),
        .mosi_o        (mosi),
        .cs_n_o        (cs_n),
        .sclk_en_o     (sclk_en),
        .busy_o        (busy),
        .done_o        (done),
        .rx_data_o     (rx_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: expected MOSI bits / rx words pushed when a transfer is driven
    logic          exp_mosi[$];
    logic          obs_mosi[$];
    logic [DW-1:0] exp_rx[$];

    // observations recorded by the stimulus driver
    int            tmo, setup_obs, hold_obs, total, cs_glitch, hold_mosi_bad, ref_total;
    logic          busy_at_done, cs_at_done, mosi_at_done, done_after, sclk_after_last;
    logic [DW-1:0] rx_at_done;
    logic          ab_cs, ab_sclk, ab_busy, ab_mosi;
    int            ab_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pat: 0 = capture then shift (CPHA0 style), 1 = shift then capture (CPHA1 style),
    //      2 = capture and shift in the same clk
    task automatic drive_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] rxw, input logic cp,
                              input int pat, input bit perturb, input int abort_bits, input bit keep_start);
        int guard;
        obs_mosi.delete();
        tmo = 0; setup_obs = 0; hold_obs = 0; total = 0; cs_glitch = 0; hold_mosi_bad = 0;
        for (int i = 0; i < DW; i++) exp_mosi.push_back(tx[DW-1-i]);
        exp_rx.push_back(rxw);
        tx_data = tx; cpha = cp; start = 1'b1;
        step(); total = 1;
        if (!keep_start) start = 1'b0;
        if (perturb) tx_data = ~tx;
        guard = 0;
        while (sclk_en !== 1'b1 && guard < 64) begin
            if (cs_n !== 1'b0) cs_glitch++;
            if (perturb) begin cap = 1'b1; shf = 1'b1; cpha = ~cpha; end
            step(); cap = 1'b0; shf = 1'b0; total++; setup_obs++; guard++;
        end
        if (guard >= 64) tmo++;
        for (int i = 0; i < DW; i++) begin
            if (pat == 1 || (pat == 0 && i > 0)) begin
                shf = 1'b1;
                if (perturb) cpha = ~cpha;
                step(); shf = 1'b0; total++;
                if (cs_n !== 1'b0) cs_glitch++;
                step(); total++;
            end
            miso = rxw[DW-1-i];
            cap = 1'b1;
            if (pat == 2) shf = 1'b1;
            @(negedge clk);
            obs_mosi.push_back(mosi);
            step(); cap = 1'b0; shf = 1'b0; total++;
            if (abort_bits == i + 1) begin
                #2 rst_n = 1'b0;
                #1;
                ab_cs = cs_n; ab_sclk = sclk_en; ab_busy = busy; ab_mosi = mosi; ab_done = 0;
                repeat (3) begin @(negedge clk); if (done === 1'b1) ab_done++; end
                rst_n = 1'b1;
                repeat (4) begin @(negedge clk); if (done === 1'b1) ab_done++; end
                step();
                return;
            end
            if (i < DW - 1) begin
                if (cs_n !== 1'b0) cs_glitch++;
                step(); total++;
            end
        end
        sclk_after_last = sclk_en;
        guard = 0;
        while (done !== 1'b1 && guard < 64) begin
            if (cs_n !== 1'b0) cs_glitch++;
            if (mosi !== tx[0]) hold_mosi_bad++;
            if (perturb) begin cap = 1'b1; shf = 1'b1; cpha = ~cpha; end
            step(); cap = 1'b0; shf = 1'b0; total++; hold_obs++; guard++;
        end
        if (guard >= 64) tmo++;
        busy_at_done = busy; cs_at_done = cs_n; mosi_at_done = mosi; rx_at_done = rx_data;
        step();
        done_after = done;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (cs_n !== 1'b1)   begin n_fail++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        n_checks++; if (mosi !== 1'b0)   begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        n_checks++; if (sclk_en !== 1'b0) begin n_fail++; $display("FAIL reset_sclk_en got=%b exp=0", sclk_en); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (rx_data !== '0)  begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mode0();
        logic e, o;
        logic [DW-1:0] er;
        drive_xfer(8'hA5, 8'h3C, 1'b0, 0, 1'b0, -1, 1'b0);
        ref_total = total;
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL mode0_timeout got=%0d exp=0", tmo); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL mode0_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL mode0_rx got=%h exp=%h", rx_at_done, er); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL mode0_busy_at_done got=%b exp=0", busy_at_done); end
        n_checks++; if (cs_at_done !== 1'b1) begin n_fail++; $display("FAIL mode0_cs_at_done got=%b exp=1", cs_at_done); end
        n_checks++; if (mosi_at_done !== 1'b0) begin n_fail++; $display("FAIL mode0_mosi_at_done got=%b exp=0", mosi_at_done); end
        n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL mode0_done_width got=%b exp=0", done_after); end
        n_checks++; if (cs_glitch !== 0) begin n_fail++; $display("FAIL mode0_cs_low got=%0d highs exp=0", cs_glitch); end
        n_checks++; if (setup_obs !== SETUP_C) begin n_fail++; $display("FAIL mode0_setup got=%0d exp=%0d", setup_obs, SETUP_C); end
        n_checks++; if (hold_obs !== HOLD_C) begin n_fail++; $display("FAIL mode0_hold got=%0d exp=%0d", hold_obs, HOLD_C); end
        n_checks++; if (sclk_after_last !== 1'b0) begin n_fail++; $display("FAIL mode0_sclk_off got=%b exp=0", sclk_after_last); end
        n_checks++; if (hold_mosi_bad !== 0) begin n_fail++; $display("FAIL mode0_hold_mosi got=%0d exp=0", hold_mosi_bad); end
    endtask

    task automatic test_mode1();
        logic e, o;
        logic [DW-1:0] er;
        drive_xfer(8'h81, 8'hFF, 1'b1, 1, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL mode1_timeout got=%0d exp=0", tmo); end
        n_checks++; if (obs_mosi.size() !== DW) begin n_fail++; $display("FAIL mode1_captures got=%0d exp=%0d", obs_mosi.size(), DW); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL mode1_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL mode1_rx got=%h exp=%h", rx_at_done, er); end
        n_checks++; if (hold_mosi_bad !== 0) begin n_fail++; $display("FAIL mode1_hold_mosi got=%0d exp=0", hold_mosi_bad); end
        n_checks++; if (hold_obs !== HOLD_C) begin n_fail++; $display("FAIL mode1_hold got=%0d exp=%0d", hold_obs, HOLD_C); end
    endtask

    task automatic test_simultaneous();
        logic e, o;
        logic [DW-1:0] er;
        drive_xfer(8'h55, 8'hA6, 1'b0, 2, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL simul_timeout got=%0d exp=0", tmo); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL simul_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL simul_rx got=%h exp=%h", rx_at_done, er); end
        n_checks++; if (hold_obs !== HOLD_C) begin n_fail++; $display("FAIL simul_hold got=%0d exp=%0d", hold_obs, HOLD_C); end
        n_checks++; if (hold_mosi_bad !== 0) begin n_fail++; $display("FAIL simul_hold_mosi got=%0d exp=0", hold_mosi_bad); end
    endtask

    task automatic test_back_to_back();
        logic e, o;
        logic [DW-1:0] er;
        drive_xfer(8'h3C, 8'hC5, 1'b0, 0, 1'b0, -1, 1'b1);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL b2b_first_timeout got=%0d exp=0", tmo); end
        n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL b2b_first_done_width got=%b exp=0", done_after); end
        n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL b2b_cs_gap got=%b exp=1", cs_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap got=%b exp=0", busy); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_first_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL b2b_first_rx got=%h exp=%h", rx_at_done, er); end
        drive_xfer(8'hE7, 8'h18, 1'b1, 1, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL b2b_second_timeout got=%0d exp=0", tmo); end
        n_checks++; if (setup_obs !== SETUP_C) begin n_fail++; $display("FAIL b2b_second_setup got=%0d exp=%0d", setup_obs, SETUP_C); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_second_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL b2b_second_rx got=%h exp=%h", rx_at_done, er); end
    endtask

    task automatic test_reset_abort();
        logic e, o;
        logic [DW-1:0] er;
        drive_xfer(8'hC3, 8'h5A, 1'b0, 0, 1'b0, 4, 1'b0);
        n_checks++; if (ab_cs !== 1'b1) begin n_fail++; $display("FAIL abort_cs_n got=%b exp=1", ab_cs); end
        n_checks++; if (ab_sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk_en got=%b exp=0", ab_sclk); end
        n_checks++; if (ab_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", ab_busy); end
        n_checks++; if (ab_mosi !== 1'b0) begin n_fail++; $display("FAIL abort_mosi got=%b exp=0", ab_mosi); end
        n_checks++; if (ab_done !== 0) begin n_fail++; $display("FAIL abort_done got=%0d pulses exp=0", ab_done); end
        n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL abort_rx_cleared got=%h exp=00", rx_data); end
        for (int i = 0; i < 4; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL abort_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        exp_mosi.delete();
        void'(exp_rx.pop_front());
        drive_xfer(8'h96, 8'h69, 1'b0, 0, 1'b0, -1, 1'b0);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL after_abort_timeout got=%0d exp=0", tmo); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL after_abort_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL after_abort_rx got=%h exp=%h", rx_at_done, er); end
    endtask

    task automatic test_perturb();
        logic e, o;
        logic [DW-1:0] er;
        drive_xfer(8'hA5, 8'h3C, 1'b0, 0, 1'b1, -1, 1'b0);
        n_checks++; if (tmo !== 0) begin n_fail++; $display("FAIL perturb_timeout got=%0d exp=0", tmo); end
        for (int i = 0; i < DW; i++) begin
            e = exp_mosi.pop_front();
            o = (obs_mosi.size() > 0) ? obs_mosi.pop_front() : 1'bx;
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL perturb_mosi bit%0d got=%b exp=%b", i, o, e); end
        end
        er = exp_rx.pop_front();
        n_checks++; if (rx_at_done !== er) begin n_fail++; $display("FAIL perturb_rx got=%h exp=%h", rx_at_done, er); end
        n_checks++; if (setup_obs !== SETUP_C) begin n_fail++; $display("FAIL perturb_setup got=%0d exp=%0d", setup_obs, SETUP_C); end
        n_checks++; if (hold_obs !== HOLD_C) begin n_fail++; $display("FAIL perturb_hold got=%0d exp=%0d", hold_obs, HOLD_C); end
        n_checks++; if (total !== ref_total) begin n_fail++; $display("FAIL perturb_latency got=%0d exp=%0d", total, ref_total); end
        n_checks++; if (hold_mosi_bad !== 0) begin n_fail++; $display("FAIL perturb_hold_mosi got=%0d exp=0", hold_mosi_bad); end
        n_checks++; if (cs_glitch !== 0) begin n_fail++; $display("FAIL perturb_cs_low got=%0d highs exp=0", cs_glitch); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_simultaneous();
        test_back_to_back();
        test_reset_abort();
        test_perturb();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Byte-transfer engine sitting directly downstream of spi_mode_config: consumes its capture_edge/shift_edge pulses to drive MOSI, sample MISO and frame the transfer with CS.
- Accepts a start request with parallel tx data, serialises it MSB-first, deserialises MISO into rx_data, and reports busy/done to the controlling logic.
- sclk_en gates the upstream SCLK source so edges only arrive during the data phase.

Parameters:
- DATA_WIDTH, 8, bits per transfer (>=2)
- SETUP_CYCLES, 2, clk cycles between CS assertion and sclk_en rising (>=1)
- HOLD_CYCLES, 2, clk cycles between last capture and CS deassertion (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  transfer request, sampled only in IDLE
- tx_data  in  DATA_WIDTH  word to transmit, latched on accepted start
- cpha  in  1  clock phase, latched on accepted start
- capture_edge  in  1  one-clk pulse from spi_mode_config: sample MISO
- shift_edge  in  1  one-clk pulse from spi_mode_config: update MOSI
- miso  in  1  serial data in, assumed already synchronised
- mosi  out  1  serial data out
- cs_n  out  1  chip select, active low
- sclk_en  out  1  enables upstream SCLK generation
- busy  out  1  high from accepted start until done
- done  out  1  one-clk pulse, transfer complete
- rx_data  out  DATA_WIDTH  last received word, stable until next done

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, cs_n=1, mosi=0, sclk_en=0, busy=0, done=0, rx_data=0, shift regs and counters 0. Reset mid-transfer aborts immediately; no done pulse.
- States: IDLE, SETUP, XFER, HOLD, FINISH.
- IDLE: start=1 -> next edge: SETUP, cs_n=0, busy=1, tx_sreg<=tx_data, cpha_q<=cpha, mosi<=tx_data[DATA_WIDTH-1], bit_cnt<=0, setup counter cleared. start while not IDLE ignored (no queuing).
- SETUP: counts SETUP_CYCLES clks, then XFER with sclk_en=1 on the same edge.
- XFER, capture_edge=1: rx_sreg<={rx_sreg[DATA_WIDTH-2:0],miso}; bit_cnt<=bit_cnt+1.
- XFER, shift_edge=1: if bit_cnt (post-capture value when simultaneous) is 1..DATA_WIDTH-1, mosi<=tx_sreg[DATA_WIDTH-1-bit_cnt]. bit_cnt=0: CPHA=0 ignores it (MSB already driven); CPHA=1 re-drives the MSB. bit_cnt=DATA_WIDTH: ignored. This single rule serves both CPHA values.
- Simultaneous capture_edge and shift_edge in the same clk: capture first, then shift using the incremented count.
- When bit_cnt reaches DATA_WIDTH on a capture: next edge sclk_en=0, state HOLD. Any edge pulses arriving in HOLD/FINISH are ignored.
- HOLD: counts HOLD_CYCLES clks, then FINISH.
- FINISH (one clk): cs_n<=1, rx_data<=rx_sreg, done=1 for exactly this cycle, busy<=0, mosi<=0, then IDLE. busy deasserts on the same edge done asserts.
- A new start may be accepted on the clk after done (back-to-back transfers allowed, CS high for at least one clk).
- cpha changes during a transfer have no effect (latched value used).
- Total latency from start to done: 1 + SETUP_CYCLES + (edge-dependent XFER) + HOLD_CYCLES + 1 clks.

Test Plan:
- Mode 0, tx_data=0xA5, MISO model returns 0x3C: mosi bit sequence 1,0,1,0,0,1,0,1 sampled at capture_edges; done pulses once; rx_data=0x3C; cs_n low throughout; busy falls with done.
- Mode 1 (cpha=1), tx_data=0x81, MISO returns 0xFF: MSB driven on first shift_edge; exactly 8 captures; rx_data=0xFF; no 9th MOSI change.
- Forced simultaneous capture_edge+shift_edge pulses on each bit, tx_data=0x55: rx/tx alignment unchanged, rx_data matches MISO word, bit_cnt stops at 8.
- start held high for full transfer plus start pulsed mid-XFER: only one transfer runs; second start accepted only in IDLE after done -> two done pulses with cs_n high >=1 clk between.
- reset driven low during XFER after 4 bits: cs_n=1, sclk_en=0, busy=0, mosi=0 within the same cycle (async); no done; next start after release transfers correctly.
- cpha toggled mid-transfer and stray edge pulses injected during SETUP/HOLD: no effect on mosi sequence, rx_data or timing.
